// File: rtl/vga_scan_timing_gen.sv
// VGA raster timing generator.
// Divides the system clock down to a pixel rate and walks X/Y over the full
// raster. The registered sync, blank and strobe outputs change on the same clk
// edge as the coordinates they describe.
module vga_scan_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_tick,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0]      VLast   = 10'(V_TOTAL - 1);

  // Window bounds are 11 bits so a window ending exactly at 1024 still decodes.
  localparam logic [10:0] HActEnd  = 11'(H_ACTIVE);
  localparam logic [10:0] HSyncBeg = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VActEnd  = 11'(V_ACTIVE);
  localparam logic [10:0] VSyncBeg = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Parameter sanity: counters are 10 bits and the divider must be non-zero.
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_scan_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_TOTAL > 1024 || H_TOTAL < 1) begin : g_bad_h_total
    $error("vga_scan_timing_gen: H_TOTAL must be in 1..1024");
  end
  if (V_TOTAL > 1024 || V_TOTAL < 1) begin : g_bad_v_total
    $error("vga_scan_timing_gen: V_TOTAL must be in 1..1024");
  end

  logic [DivW-1:0] div_q, div_d;
  logic            tick_en;
  logic            tick_q;
  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic            line_wrap, frame_wrap;
  logic            video_on_q, video_on_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            line_end_q, line_end_d;
  logic            frame_start_q, frame_start_d;

  // Clock divider: tick_en marks the clk whose edge advances the raster.
  always_comb begin
    tick_en = (div_q == DivLast);
    div_d   = tick_en ? '0 : div_q + 1'b1;
  end

  // Raster counters: X runs across the line, Y steps when X wraps.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    line_wrap  = (x_q == HLast);
    frame_wrap = line_wrap && (y_q == VLast);
    if (tick_en) begin
      if (line_wrap) begin
        x_d = '0;
        y_d = frame_wrap ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Decode from the next coordinates so the registered flags line up with X/Y.
  always_comb begin
    video_on_d    = ({1'b0, x_d} < HActEnd) && ({1'b0, y_d} < VActEnd);
    hsync_d       = (({1'b0, x_d} >= HSyncBeg) && ({1'b0, x_d} < HSyncEnd)) ? SYNC_POL
                                                                              : ~SYNC_POL;
    vsync_d       = (({1'b0, y_d} >= VSyncBeg) && ({1'b0, y_d} < VSyncEnd)) ? SYNC_POL
                                                                              : ~SYNC_POL;
    line_end_d    = tick_en && line_wrap;
    frame_start_d = tick_en && frame_wrap;
  end

  // State registers. Raster-derived flags only load on a tick, which keeps them
  // at their reset values until the first pixel step after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      tick_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      tick_q        <= tick_en;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
      if (tick_en) begin
        x_q        <= x_d;
        y_q        <= y_d;
        video_on_q <= video_on_d;
        hsync_q    <= hsync_d;
        vsync_q    <= vsync_d;
      end
    end
  end

  // Outputs are straight register taps.
  always_comb begin
    pixel_tick  = tick_q;
    X           = x_q;
    Y           = y_q;
    video_on    = video_on_q;
    hsync       = hsync_q;
    vsync       = vsync_q;
    line_end    = line_end_q;
    frame_start = frame_start_q;
  end

endmodule

// File: tb/tb_vga_scan_timing_gen.sv
// Self-checking bench for vga_scan_timing_gen.
// u_dut0: default 640x480 timing, CLK_DIV=4, active-low sync.
// u_dut1: tiny 15x10 raster, CLK_DIV=3, active-low sync (frame and reset cases).
// u_dut2: same tiny raster, CLK_DIV=1, active-high sync.
// A clock-count model checks every output of every instance each clk; directed
// sequences add hand-computed checks for the interesting points.
module tb_vga_scan_timing_gen;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;

  logic       tick0, von0, hs0, vs0, le0, fs0;
  logic [9:0] x0, y0;
  logic       tick1, von1, hs1, vs1, le1, fs1;
  logic [9:0] x1, y1;
  logic       tick2, von2, hs2, vs2, le2, fs2;
  logic [9:0] x2, y2;

  int n_checks = 0;
  int n_fail   = 0;
  int n0 = 0, n1 = 0, n2 = 0;

  always #5 clk = ~clk;

  vga_scan_timing_gen u_dut0 (
    .clk(clk), .reset(rst0), .pixel_tick(tick0), .X(x0), .Y(y0), .video_on(von0),
    .hsync(hs0), .vsync(vs0), .line_end(le0), .frame_start(fs0)
  );

  vga_scan_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) u_dut1 (
    .clk(clk), .reset(rst1), .pixel_tick(tick1), .X(x1), .Y(y1), .video_on(von1),
    .hsync(hs1), .vsync(vs1), .line_end(le1), .frame_start(fs1)
  );

  vga_scan_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) u_dut2 (
    .clk(clk), .reset(rst2), .pixel_tick(tick2), .X(x2), .Y(y2), .video_on(von2),
    .hsync(hs2), .vsync(vs2), .line_end(le2), .frame_start(fs2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Clock-count model: n clk edges since reset release give n/d pixel steps.
  task automatic model_check(
    input string nm, input int n, input int d,
    input int ha, input int hf, input int hsw, input int hb,
    input int va, input int vf, input int vsw, input int vb, input bit pol,
    input logic tick, input logic [9:0] x, input logic [9:0] y,
    input logic von, input logic hs, input logic vs, input logic le, input logic fs
  );
    int ht, vt, t, pos, ex, ey;
    bit etick, evon, ehs, evs;
    ht    = ha + hf + hsw + hb;
    vt    = va + vf + vsw + vb;
    t     = n / d;
    pos   = t % (ht * vt);
    ex    = pos % ht;
    ey    = pos / ht;
    etick = (n >= 1) && (n % d == 0);
    evon  = (t > 0) && (ex < ha) && (ey < va);
    ehs   = ((t > 0) && (ex >= ha + hf) && (ex < ha + hf + hsw)) ? pol : !pol;
    evs   = ((t > 0) && (ey >= va + vf) && (ey < va + vf + vsw)) ? pol : !pol;
    check({nm, ".tick"}, tick, etick);
    check({nm, ".x"}, x, ex);
    check({nm, ".y"}, y, ey);
    check({nm, ".video_on"}, von, evon);
    check({nm, ".hsync"}, hs, ehs);
    check({nm, ".vsync"}, vs, evs);
    check({nm, ".line_end"}, le, etick && (ex == 0));
    check({nm, ".frame_start"}, fs, etick && (pos == 0));
    check({nm, ".x_in_range"}, x < ht, 1);
    check({nm, ".y_in_range"}, y < vt, 1);
  endtask

  always @(posedge clk or posedge rst0) if (rst0) n0 <= 0; else n0 <= n0 + 1;
  always @(posedge clk or posedge rst1) if (rst1) n1 <= 0; else n1 <= n1 + 1;
  always @(posedge clk or posedge rst2) if (rst2) n2 <= 0; else n2 <= n2 + 1;

  always @(negedge clk) begin
    model_check("d0", n0, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                tick0, x0, y0, von0, hs0, vs0, le0, fs0);
    model_check("d1", n1, 3, 8, 2, 3, 2, 6, 1, 2, 1, 1'b0,
                tick1, x1, y1, von1, hs1, vs1, le1, fs1);
    model_check("d2", n2, 1, 8, 2, 3, 2, 6, 1, 2, 1, 1'b1,
                tick2, x2, y2, von2, hs2, vs2, le2, fs2);
  end

  initial begin
    int ticks, hs_cnt, hs_min, hs_max, fs_cnt, von_cnt, vs_cnt, y_min, y_max;
    bit wrap_seen, found;

    // Reset held for 5 clks: everything at reset values.
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst.x", x0, 0);
    check("rst.y", y0, 0);
    check("rst.tick", tick0, 0);
    check("rst.video_on", von0, 0);
    check("rst.hsync", hs0, 1);
    check("rst.vsync", vs0, 1);
    check("rst.hsync_pos", hs2, 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    rst2 = 1'b0;

    // First pixel step lands on clk 4 after release.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("t1.tick_low", tick0, 0);
      check("t1.x_hold", x0, 0);
      check("t1.video_off", von0, 0);
    end
    @(negedge clk);
    check("t1.tick", tick0, 1);
    check("t1.x", x0, 1);
    check("t1.y", y0, 0);
    check("t1.video_on", von0, 1);
    check("t1.line_end", le0, 0);

    // One full line of 800 ticks: wrap strobe and hsync window.
    ticks = 0; hs_cnt = 0; hs_min = 9999; hs_max = -1; wrap_seen = 0;
    for (int c = 0; c < 3300 && ticks < 800; c++) begin
      @(negedge clk);
      if (tick0) begin
        ticks++;
        if (!hs0) begin
          hs_cnt++;
          if (int'(x0) < hs_min) hs_min = int'(x0);
          if (int'(x0) > hs_max) hs_max = int'(x0);
        end
        if (x0 == 10'd0 && !wrap_seen) begin
          wrap_seen = 1;
          check("t2.wrap_line_end", le0, 1);
          check("t2.wrap_y", y0, 1);
        end
      end
    end
    check("t2.ticks", ticks, 800);
    check("t2.wrap_seen", wrap_seen, 1);
    check("t2.hsync_ticks", hs_cnt, 96);
    check("t2.hsync_first_x", hs_min, 656);
    check("t2.hsync_last_x", hs_max, 751);

    // Small raster frame: one frame_start per frame, vsync and blanking windows.
    found = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      if (fs1) found = 1;
    end
    check("t3.frame_start_found", found, 1);
    check("t3.fs_x", x1, 0);
    check("t3.fs_y", y1, 0);
    check("t3.fs_line_end", le1, 1);
    ticks = 0; fs_cnt = 0; von_cnt = 0; vs_cnt = 0; y_min = 9999; y_max = -1;
    for (int c = 0; c < 500 && ticks < 150; c++) begin
      @(negedge clk);
      if (tick1) begin
        ticks++;
        if (fs1) fs_cnt++;
        if (von1) von_cnt++;
        if (!vs1) begin
          vs_cnt++;
          if (int'(y1) < y_min) y_min = int'(y1);
          if (int'(y1) > y_max) y_max = int'(y1);
        end
      end
    end
    check("t3.ticks", ticks, 150);
    check("t3.frame_starts", fs_cnt, 1);
    check("t3.video_ticks", von_cnt, 48);
    check("t3.vsync_ticks", vs_cnt, 30);
    check("t3.vsync_first_y", y_min, 7);
    check("t3.vsync_last_y", y_max, 8);

    // Asynchronous reset mid-tick at X=5,Y=3.
    found = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      if (tick1 && x1 == 10'd5 && y1 == 10'd3) found = 1;
    end
    check("t4.target_found", found, 1);
    check("t4.video_before", von1, 1);
    @(negedge clk);
    #2 rst1 = 1'b1;
    #1;
    check("t4.x_async", x1, 0);
    check("t4.y_async", y1, 0);
    check("t4.div_async", u_dut1.div_q, 0);
    check("t4.tick_async", tick1, 0);
    check("t4.video_async", von1, 0);
    check("t4.hsync_async", hs1, 1);
    check("t4.vsync_async", vs1, 1);
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    repeat (2) @(negedge clk);
    check("t4.no_early_tick", tick1, 0);
    @(negedge clk);
    check("t4.resume_tick", tick1, 1);
    check("t4.resume_x", x1, 1);
    check("t4.resume_y", y1, 0);
    check("t4.no_frame_start", fs1, 0);

    // CLK_DIV=1, active-high sync: tick every clk, hsync high only for X=10..12.
    hs_cnt = 0; hs_min = 9999; hs_max = -1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check("t5.tick_const", tick2, 1);
      if (hs2) begin
        hs_cnt++;
        if (int'(x2) < hs_min) hs_min = int'(x2);
        if (int'(x2) > hs_max) hs_max = int'(x2);
      end
    end
    check("t5.hsync_clks", hs_cnt, 3);
    check("t5.hsync_first_x", hs_min, 10);
    check("t5.hsync_last_x", hs_max, 12);

    // Two whole frames on the fast instance; the model checks ranges every clk.
    fs_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (fs2) fs_cnt++;
    end
    check("t6.frame_starts_2f", fs_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
